freq_meter: RTL and testbench
=============================

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter CNT_W, default 26, width of the half-period counter and result (26 bits covers one 50 MHz second).
REQ-002 Parameter MIN_HALF, default 2, smallest legal half-period in clockIn cycles; shorter intervals are glitches.
REQ-003 clockIn  input  1  single system clock, 50 MHz; all state on its rising edge.
REQ-004 resetN  input  1  reset, asynchronous assert, active-low.
REQ-005 sigIn  input  1  asynchronous square wave to measure, e.g. a clockDivider output or an external strobe.
REQ-006 divOut  output  CNT_W  measured half-period minus one, i.e. the divValue that regenerates sigIn from clockIn.
REQ-007 measValid  output  1  one-cycle pulse when divOut updates.
REQ-008 overflow  output  1  sticky; set when no sigIn edge arrives within 2^CNT_W-1 cycles.
REQ-009 glitch  output  1  one-cycle pulse when an edge interval is below MIN_HALF.
REQ-010 locked  output  1  two consecutive equal half-periods measured (only with FREQ_METER_LOCK_EN, else tied 0).

Function
REQ-011 sigIn SHALL pass a 2-flop synchronizer, then one edge-detect register; an edge (either polarity) is flagged 3 cycles after a sigIn transition.
REQ-012 FSM states: IDLE (wait first edge), MEASURE (counting); transitions: IDLE->MEASURE on edge; MEASURE->MEASURE on edge; MEASURE->IDLE on overflow.
REQ-013 On entering MEASURE or on each edge in MEASURE, counter SHALL load 1; every other MEASURE cycle it increments by 1.
REQ-014 On an edge in MEASURE with counter N >= MIN_HALF: divOut <= N-1 and measValid = 1 in the next cycle; a clockDivider with divValue D yields divOut = D.
REQ-015 On an edge with N < MIN_HALF: divOut unchanged, measValid stays 0, glitch pulses 1 cycle, counter reloads 1.
REQ-016 Counter reaching 2^CNT_W-1 without an edge: overflow <= 1, FSM -> IDLE, divOut unchanged; counter never wraps.
REQ-017 overflow SHALL clear only on reset or on the next valid measurement (measValid).
REQ-018 The first edge after IDLE SHALL NOT produce measValid (no reference interval).
REQ-019 Edge and overflow in the same cycle: edge wins, measurement taken with N = 2^CNT_W-1, overflow not set.

Reset
REQ-020 resetN low SHALL immediately force: FSM IDLE, counter 0, synchronizer and edge registers 0, divOut 0, measValid 0, overflow 0, glitch 0, locked 0.
REQ-021 Reset mid-MEASURE SHALL discard the partial count; after release the first edge only arms (REQ-018).
REQ-022 Release of resetN is synchronous to clockIn via the instantiating top level; the block itself adds no release synchronizer.

Configuration
REQ-023 Macro FREQ_METER_LOCK_EN defined: block keeps previous divOut; locked <= 1 when new result equals previous, <= 0 when it differs, on glitch, or on overflow.
REQ-024 Macro FREQ_METER_LOCK_EN undefined: no comparison register, locked constant 0, all other behaviour identical.

Structure
REQ-025 Package freq_meter_pkg SHALL hold the FSM state encoding (IDLE=0, MEASURE=1), SYNC_STAGES=2, and the default CNT_W.
REQ-026 Sub-module edgeSync SHALL contain the synchronizer and edge detector (ports clockIn, resetN, sigIn, edgePulse); freq_meter instantiates it once.
REQ-027 Target size 150-250 lines RTL including edgeSync.

Verification
REQ-028 sigIn toggles every 4 clockIn cycles -> second and later edges give measValid with divOut=3; first edge gives no measValid.
REQ-029 sigIn from a clockDivider with divValue=9 (10-cycle half period) and LOCK_EN -> divOut=9, locked=1 after second measurement; period changed to 6 cycles -> next measValid divOut=5, locked=0, following one locked=1.
REQ-030 CNT_W=8, sigIn held constant after arming -> overflow=1 after 255 cycles, FSM IDLE; resume 4-cycle toggling -> first edge arms, next measValid divOut=3, overflow=0.
REQ-031 1-cycle pulse on sigIn between 8-cycle half periods -> glitch pulses, no measValid for short interval, divOut keeps 7.
REQ-032 resetN asserted 5 cycles into a 20-cycle half period -> all outputs 0 immediately; after release first edge arms only, second edge divOut=19.
REQ-033 LOCK_EN undefined build, same stimulus as REQ-029 -> identical divOut/measValid, locked constant 0.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter: FSM encoding, synchronizer depth
// and the default counter width.
package freq_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } fm_state_e;

    localparam int SYNC_STAGES   = 2;
    localparam int CNT_W_DEFAULT = 26;

endpackage

// File: rtl/freq_meter_edgesync.sv
// edgeSync: brings the asynchronous sigIn into the clockIn domain and flags
// every transition (either polarity) as a single-cycle edgePulse.
module edgeSync
    import freq_meter_pkg::*;
(
    input  logic clockIn,
    input  logic resetN,
    input  logic sigIn,
    output logic edgePulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clockIn or negedge resetN) begin
        if (!resetN) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sigIn};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // High for exactly one cycle after the synchronized level changes.
    assign edgePulse = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: measures the half-period of sigIn in clockIn cycles and reports it
// as a clock-divider value. Define FREQ_METER_LOCK_EN to add the locked indicator.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int MIN_HALF = 2
) (
    input  logic             clockIn,
    input  logic             resetN,
    input  logic             sigIn,
    output logic [CNT_W-1:0] divOut,
    output logic             measValid,
    output logic             overflow,
    output logic             glitch,
    output logic             locked,
    output logic             fsmState
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_N   = CNT_W'(MIN_HALF);

    fm_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             meas_q, meas_d;
    logic             ovf_q, ovf_d;
    logic             glitch_q, glitch_d;
    logic             ovf_hit;
    logic             edge_w;

    edgeSync u_edge_sync (
        .clockIn  (clockIn),
        .resetN   (resetN),
        .sigIn    (sigIn),
        .edgePulse(edge_w)
    );

    always_ff @(posedge clockIn or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            meas_q   <= 1'b0;
            ovf_q    <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            meas_q   <= meas_d;
            ovf_q    <= ovf_d;
            glitch_q <= glitch_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        meas_d   = 1'b0;
        ovf_d    = ovf_q;
        glitch_d = 1'b0;
        ovf_hit  = 1'b0;
        case (state_q)
            IDLE: begin
                // First edge only arms: there is no reference interval yet.
                if (edge_w) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
                end
            end
            MEASURE: begin
                // An edge takes priority over a simultaneous counter saturation.
                if (edge_w) begin
                    cnt_d = CNT_ONE;
                    if (cnt_q >= MIN_N) begin
                        div_d  = cnt_q - CNT_ONE;
                        meas_d = 1'b1;
                        ovf_d  = 1'b0;
                    end else begin
                        glitch_d = 1'b1;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    ovf_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (ovf_hit) begin
            ovf_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

`ifdef FREQ_METER_LOCK_EN
    logic locked_q;

    // div_q still holds the previous result when a new one is being written.
    always_ff @(posedge clockIn or negedge resetN) begin
        if (!resetN) begin
            locked_q <= 1'b0;
        end else if (meas_d) begin
            locked_q <= (div_d == div_q);
        end else if (glitch_d || ovf_hit) begin
            locked_q <= 1'b0;
        end
    end

    assign locked = locked_q;
`else
    assign locked = 1'b0;
`endif

    assign divOut    = div_q;
    assign measValid = meas_q;
    assign overflow  = ovf_q;
    assign glitch    = glitch_q;
    assign fsmState  = state_q;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: default-width instance for measurement, lock,
// glitch and reset behaviour, plus an 8-bit instance for overflow.
module tb_freq_meter;

`ifdef FREQ_METER_LOCK_EN
    localparam logic LOCK_ON = 1'b1;
`else
    localparam logic LOCK_ON = 1'b0;
`endif

    // Clock / reset
    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    logic        sig = 1'b0;
    logic [25:0] div_o;
    logic        meas_o, ovf_o, glitch_o, lock_o, fsm_o;

    logic        sig2 = 1'b0;
    logic [7:0]  div2_o;
    logic        meas2_o, ovf2_o, glitch2_o, lock2_o, fsm2_o;

    freq_meter u_dut (
        .clockIn(clk), .resetN(resetN), .sigIn(sig),
        .divOut(div_o), .measValid(meas_o), .overflow(ovf_o),
        .glitch(glitch_o), .locked(lock_o), .fsmState(fsm_o)
    );

    freq_meter #(.CNT_W(8)) u_ovf (
        .clockIn(clk), .resetN(resetN), .sigIn(sig2),
        .divOut(div2_o), .measValid(meas2_o), .overflow(ovf2_o),
        .glitch(glitch2_o), .locked(lock2_o), .fsmState(fsm2_o)
    );

    // Event collector, sampled 2 ns after each rising edge.
    int          meas_cnt = 0, glitch_cnt = 0, meas2_cnt = 0;
    logic [25:0] last_div = '0;
    logic        last_lock = 1'b0;
    logic [7:0]  last_div2 = '0;

    always @(posedge clk) begin
        #2;
        if (meas_o) begin
            meas_cnt++;
            last_div  = div_o;
            last_lock = lock_o;
        end
        if (glitch_o) glitch_cnt++;
        if (meas2_o) begin
            meas2_cnt++;
            last_div2 = div2_o;
        end
    end

    // Check bookkeeping
    int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_half(input int len);
        sig = ~sig;
        tick(len);
    endtask

    task automatic run_half2(input int len);
        sig2 = ~sig2;
        tick(len);
    endtask

    task automatic do_reset();
        sig    = 1'b0;
        sig2   = 1'b0;
        resetN = 1'b0;
        tick(3);
        resetN = 1'b1;
        tick(3);
    endtask

    int m0, g0, m2, cycles;

    initial begin
        tick(3);
        resetN = 1'b1;
        tick(2);
        check("rst_div", div_o, 0);
        check("rst_meas", meas_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_glitch", glitch_o, 0);
        check("rst_lock", lock_o, 0);
        check("rst_fsm", fsm_o, 0);

        // 4-cycle half period
        run_half(4);
        check("h4_arm_meas", meas_cnt, 0);
        check("h4_arm_fsm", fsm_o, 1);
        run_half(4);
        check("h4_first_meas", meas_cnt, 1);
        check("h4_first_div", last_div, 3);
        run_half(4);
        run_half(4);
        run_half(4);
        check("h4_meas_total", meas_cnt, 4);
        check("h4_div", div_o, 3);

        // divider 9 (10-cycle half), then 6-cycle half; lock behaviour
        do_reset();
        m0 = meas_cnt;
        run_half(10);
        check("d9_arm_meas", meas_cnt - m0, 0);
        run_half(10);
        check("d9_meas1", meas_cnt - m0, 1);
        check("d9_div1", last_div, 9);
        check("d9_lock1", last_lock, 0);
        run_half(10);
        check("d9_div2", last_div, 9);
        check("d9_lock2", last_lock, LOCK_ON);
        run_half(6);
        check("d9_div3", last_div, 9);
        run_half(6);
        check("d5_div1", last_div, 5);
        check("d5_lock1", last_lock, 0);
        run_half(6);
        check("d5_div2", last_div, 5);
        check("d5_lock2", last_lock, LOCK_ON);
        check("d5_meas_total", meas_cnt - m0, 5);

        // glitch: 1-cycle pulse between 8-cycle halves
        run_half(8);
        run_half(8);
        check("g_pre_div", last_div, 7);
        m0 = meas_cnt;
        g0 = glitch_cnt;
        run_half(1);
        run_half(8);
        check("g_meas_delta", meas_cnt - m0, 1);
        check("g_glitch_delta", glitch_cnt - g0, 1);
        check("g_div_kept", div_o, 7);
        run_half(8);
        check("g_post_meas", meas_cnt - m0, 2);
        check("g_post_glitch", glitch_cnt - g0, 1);
        check("g_post_div", last_div, 7);
        check("g_post_lock", last_lock, LOCK_ON);

        // reset 5 cycles into a 20-cycle half
        if (sig == 1'b0) run_half(8);
        run_half(5);
        check("r_pre_div", div_o, 7);
        resetN = 1'b0;
        #1;
        check("r_div", div_o, 0);
        check("r_meas", meas_o, 0);
        check("r_ovf", ovf_o, 0);
        check("r_glitch", glitch_o, 0);
        check("r_lock", lock_o, 0);
        check("r_fsm", fsm_o, 0);
        tick(2);
        resetN = 1'b1;
        tick(3);
        m0 = meas_cnt;
        run_half(20);
        check("r_arm_meas", meas_cnt - m0, 0);
        check("r_arm_fsm", fsm_o, 1);
        run_half(20);
        check("r_meas", meas_cnt - m0, 1);
        check("r_div19", last_div, 19);

        // overflow on the 8-bit instance
        m2 = meas2_cnt;
        run_half2(5);
        run_half2(5);
        sig2 = ~sig2;
        cycles = 0;
        while (!ovf2_o && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
        check("o_cycles", cycles, 258);
        check("o_flag", ovf2_o, 1);
        check("o_fsm", fsm2_o, 0);
        check("o_div_kept", div2_o, 4);
        check("o_meas", meas2_cnt - m2, 2);
        tick(10);
        run_half2(4);
        check("o_arm_meas", meas2_cnt - m2, 2);
        check("o_sticky", ovf2_o, 1);
        run_half2(4);
        check("o_resume_meas", meas2_cnt - m2, 3);
        check("o_resume_div", last_div2, 3);
        check("o_cleared", ovf2_o, 0);
        check("o_lock_off", lock2_o, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
